// File: rtl/sha_pkg.sv
// Shared types and constants for the two-block SHA-256 compression sequencer.
package sha_pkg;

  localparam int unsigned SHA_ROUNDS      = 64;
  localparam int unsigned SHA_SCHED_WORDS = 16;
  localparam int unsigned IDX_W           = 6;
  localparam int unsigned BLK_W           = 2;

  localparam logic [BLK_W-1:0] BLK_IV   = 2'd0;
  localparam logic [BLK_W-1:0] BLK_ACC1 = 2'd1;
  localparam logic [BLK_W-1:0] BLK_ACC2 = 2'd2;

  typedef enum logic [7:0] {
    ST_IDLE   = 8'b0000_0001,
    ST_LOAD1  = 8'b0000_0010,
    ST_ROUND1 = 8'b0000_0100,
    ST_ACC1   = 8'b0000_1000,
    ST_LOAD2  = 8'b0001_0000,
    ST_ROUND2 = 8'b0010_0000,
    ST_ACC2   = 8'b0100_0000,
    ST_DONE   = 8'b1000_0000
  } state_t;

endpackage

// File: rtl/round_counter.sv
// Round index counter shared by both compression blocks; flags the final round.
module round_counter
  import sha_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA_ROUNDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] count,
  output logic             last_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + IDX_W'(1);
    end
  end

  assign last_c = (count == IDX_W'(ROUNDS - 1));

endmodule

// File: rtl/sha_block_sequencer.sv
// Sequences H reset / block-1 / block-2 accumulation for one mining job and
// returns the result through a done/ack handshake with an auto-incrementing nonce.
module sha_block_sequencer
  import sha_pkg::*;
#(
  parameter int unsigned ROUNDS  = SHA_ROUNDS,
  parameter int unsigned NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               nonce_load,
  input  logic [NONCE_W-1:0] nonce_init,
  input  logic               ack,
  output logic [BLK_W-1:0]   block_sel,
  output logic               round_en,
  output logic [IDX_W-1:0]   round_idx,
  output logic               w_load,
  output logic               msg_half,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               done,
  output logic               nonce_wrap
);

  state_t           state;
  state_t           state_nxt;
  logic             last_c;
  logic             cnt_clr;
  logic             cnt_en;
  logic             in_round;
  logic             nxt_round;
  logic             nxt_load;
  logic [BLK_W-1:0] block_sel_nxt;
  logic             w_load_nxt;
  logic             msg_half_nxt;
  logic             busy_nxt;

  round_counter #(.ROUNDS(ROUNDS)) u_round_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (round_idx),
    .last_c (last_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are computed for the upcoming state so they can be registered.
  always_comb begin
    state_nxt     = state;
    in_round      = 1'b0;
    nxt_round     = 1'b0;
    nxt_load      = 1'b0;
    cnt_en        = 1'b0;
    cnt_clr       = 1'b1;
    block_sel_nxt = block_sel;
    w_load_nxt    = 1'b0;
    msg_half_nxt  = 1'b0;
    busy_nxt      = 1'b0;

    unique case (state)
      ST_IDLE:   if (!nonce_load && start) state_nxt = ST_LOAD1;
      ST_LOAD1:  state_nxt = ST_ROUND1;
      ST_ROUND1: if (last_c) state_nxt = ST_ACC1;
      ST_ACC1:   state_nxt = ST_LOAD2;
      ST_LOAD2:  state_nxt = ST_ROUND2;
      ST_ROUND2: if (last_c) state_nxt = ST_ACC2;
      ST_ACC2:   state_nxt = ST_DONE;
      ST_DONE:   if (ack) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    in_round  = (state == ST_ROUND1) || (state == ST_ROUND2);
    nxt_round = (state_nxt == ST_ROUND1) || (state_nxt == ST_ROUND2);
    nxt_load  = (state_nxt == ST_LOAD1) || (state_nxt == ST_LOAD2);
    cnt_en    = in_round && !last_c;
    cnt_clr   = !cnt_en;

    unique case (state_nxt)
      ST_LOAD1: block_sel_nxt = BLK_IV;
      ST_ACC1:  block_sel_nxt = BLK_ACC1;
      ST_ACC2:  block_sel_nxt = BLK_ACC2;
      default:  block_sel_nxt = block_sel;
    endcase

    // Message words feed W directly for the first SHA_SCHED_WORDS rounds.
    w_load_nxt   = nxt_load ||
                   (nxt_round && (!in_round || (round_idx < IDX_W'(SHA_SCHED_WORDS - 1))));
    msg_half_nxt = state_nxt inside {ST_LOAD2, ST_ROUND2, ST_ACC2};
    busy_nxt     = !(state_nxt inside {ST_IDLE, ST_DONE});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_sel  <= BLK_IV;
      round_en   <= 1'b0;
      w_load     <= 1'b0;
      msg_half   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nonce      <= '0;
      nonce_wrap <= 1'b0;
    end else begin
      block_sel <= block_sel_nxt;
      round_en  <= nxt_round;
      w_load    <= w_load_nxt;
      msg_half  <= msg_half_nxt;
      busy      <= busy_nxt;
      done      <= (state_nxt == ST_DONE);
      if ((state == ST_IDLE) && nonce_load) begin
        nonce      <= nonce_init;
        nonce_wrap <= 1'b0;
      end else if ((state == ST_DONE) && ack) begin
        nonce <= nonce + NONCE_W'(1);
        if (&nonce) nonce_wrap <= 1'b1;
      end
    end
  end

endmodule
